// File: rtl/mod_updown_counter_pkg.sv
// Shared types and constants for the up/down counter and its reference model.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Next-value select codes for the count register.
  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_ZERO = 2'd1;
  localparam logic [1:0] SEL_LOAD = 2'd2;
  localparam logic [1:0] SEL_STEP = 2'd3;

  function automatic int presc_w(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle of the up/down counter; the counter is the slave side.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             enable;
  logic             up_down;
  logic [WIDTH-1:0] data_out;
  logic             tc;
  logic             wrap;
  logic             ovf_sticky;

  modport master (
    output clear, load, data_in, enable, up_down,
    input  data_out, tc, wrap, ovf_sticky
  );

  modport slave (
    input  clear, load, data_in, enable, up_down,
    output data_out, tc, wrap, ovf_sticky
  );
endinterface

// File: rtl/mod_updown_counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is combinational and equals enable when PRESCALE=1.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic tick
);
  localparam int            PW   = presc_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] phase;

  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE out of range 1..256");
  end

  assign tick = enable && (phase == LAST);

  always_ff @(posedge clock) begin
    if (rst || restart) begin
      phase <= '0;
    end else if (enable) begin
      phase <= (phase == LAST) ? '0 : phase + ONE;
    end
  end
endmodule

// File: rtl/mod_updown_counter.sv
// Loadable up/down modulo counter with prescaler, terminal count and wrap flags.
// MOD_UPDOWN_COUNTER_SAT_EN selects saturate-at-limit instead of wrap-around.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter logic [32:0] MOD_MAX  = (33'd1 << WIDTH) - 33'd1,
  parameter int          PRESCALE = 1
) (
  input  logic                 clock,
  input  logic                 rst,
  mod_updown_counter_if.slave  bus
);
  localparam logic [WIDTH:0]   MAX_X = MOD_MAX[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_W = MOD_MAX[WIDTH-1:0];
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  localparam bit WRAP_EN = 1'b0;
`else
  localparam bit WRAP_EN = 1'b1;
`endif

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH out of range 2..32");
  end
  if (MOD_MAX >= (33'd1 << WIDTH)) begin : g_bad_mod
    $error("mod_updown_counter: MOD_MAX must be below 2**WIDTH");
  end

  dir_e             dir;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic             wrap_q;
  logic             ovf_q;
  logic [WIDTH:0]   up_x;
  logic             at_limit;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       sel;

  assign dir = dir_e'(bus.up_down);

  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock   (clock),
    .rst     (rst),
    .restart (rst | bus.clear | bus.load),
    .enable  (bus.enable),
    .tick    (tick)
  );

  // The increment is compared one bit wider so a sub-power-of-two modulus never aliases.
  assign up_x     = {1'b0, count} + ONE_X;
  assign at_limit = (dir == DIR_UP) ? (up_x > MAX_X) : (count == '0);
  assign load_val = ({1'b0, bus.data_in} > MAX_X) ? MAX_W : bus.data_in;

  always_comb begin
    step_val = count;
    if (!at_limit) begin
      step_val = (dir == DIR_UP) ? up_x[WIDTH-1:0] : count - ONE_W;
    end else if (WRAP_EN) begin
      step_val = (dir == DIR_UP) ? '0 : MAX_W;
    end
  end

  always_comb begin
    sel = SEL_HOLD;
    if (bus.clear)     sel = SEL_ZERO;
    else if (bus.load) sel = SEL_LOAD;
    else if (tick)     sel = SEL_STEP;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      count  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (sel)
        SEL_ZERO: begin
          count  <= '0;
          wrap_q <= 1'b0;
          ovf_q  <= 1'b0;
        end
        SEL_LOAD: begin
          count  <= load_val;
          wrap_q <= 1'b0;
        end
        SEL_STEP: begin
          count  <= step_val;
          wrap_q <= WRAP_EN && at_limit;
          if (at_limit) ovf_q <= 1'b1;
        end
        default: wrap_q <= 1'b0;
      endcase
    end
  end

  assign bus.data_out   = count;
  assign bus.tc         = (dir == DIR_UP) ? (count == MAX_W) : (count == '0);
  assign bus.wrap       = wrap_q;
  assign bus.ovf_sticky = ovf_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: vector table on a modulus-10 counter, hand sequence on a prescale-3 copy.
module tb_mod_updown_counter;
  import counter_pkg::*;

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   failures;

  mod_updown_counter_if #(.WIDTH(4)) bus_a ();
  mod_updown_counter_if #(.WIDTH(4)) bus_b ();

  mod_updown_counter #(.WIDTH(4), .MOD_MAX(33'd9), .PRESCALE(1)) dut_a (
    .clock (clock),
    .rst   (rst_a),
    .bus   (bus_a.slave)
  );

  mod_updown_counter #(.WIDTH(4), .MOD_MAX(33'd9), .PRESCALE(3)) dut_b (
    .clock (clock),
    .rst   (rst_b),
    .bus   (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int rst, clear, load, din, en, up;
    int q, tc, wrap, ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int r, c, l, din, e, u, q, t, w, o);
    vec_t v;
    v = '{rst: r, clear: c, load: l, din: din, en: e, up: u, q: q, tc: t, wrap: w, ovf: o};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp_b[17];
    int en_b[17];
    checks   = 0;
    failures = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.clear = 1'b0; bus_a.load = 1'b0; bus_a.data_in = '0; bus_a.enable = 1'b0; bus_a.up_down = 1'b1;
    bus_b.clear = 1'b0; bus_b.load = 1'b0; bus_b.data_in = '0; bus_b.enable = 1'b0; bus_b.up_down = 1'b1;

    //   rst clr ld din en up |  q            tc          wrap        ovf
    add(1, 0, 1, 7,  0, 1,   0,            0,          0,          0);
    add(0, 0, 1, 7,  0, 1,   7,            0,          0,          0);
    add(0, 0, 1, 12, 0, 1,   9,            1,          0,          0);
    add(0, 0, 1, 8,  0, 1,   8,            0,          0,          0);
    add(0, 0, 0, 0,  1, 1,   9,            1,          0,          0);
    add(0, 0, 0, 0,  1, 1,   SAT ? 9 : 0,  SAT ? 1 : 0, SAT ? 0 : 1, 1);
    add(0, 0, 0, 0,  1, 1,   SAT ? 9 : 1,  SAT ? 1 : 0, 0,          1);
    add(0, 0, 0, 0,  0, 1,   SAT ? 9 : 1,  SAT ? 1 : 0, 0,          1);
    add(0, 0, 0, 0,  0, 0,   SAT ? 9 : 1,  0,          0,          1);
    add(0, 0, 0, 0,  1, 0,   SAT ? 8 : 0,  SAT ? 0 : 1, 0,          1);
    add(0, 1, 0, 0,  0, 0,   0,            1,          0,          0);
    add(0, 0, 1, 1,  0, 0,   1,            0,          0,          0);
    add(0, 0, 0, 0,  1, 0,   0,            1,          0,          0);
    add(0, 0, 0, 0,  1, 0,   SAT ? 0 : 9,  SAT ? 1 : 0, SAT ? 0 : 1, 1);
    add(0, 0, 0, 0,  0, 0,   SAT ? 0 : 9,  SAT ? 1 : 0, 0,          1);
    add(0, 1, 1, 5,  0, 1,   0,            0,          0,          0);
    add(0, 0, 1, 5,  0, 1,   5,            0,          0,          0);
    add(0, 0, 1, 3,  1, 1,   3,            0,          0,          0);
    add(0, 0, 1, 9,  0, 1,   9,            1,          0,          0);
    add(0, 0, 0, 0,  1, 1,   SAT ? 9 : 0,  SAT ? 1 : 0, SAT ? 0 : 1, 1);
    add(1, 0, 1, 5,  1, 1,   0,            0,          0,          0);
    add(0, 0, 1, 9,  0, 1,   9,            1,          0,          0);
    add(0, 0, 0, 0,  1, 1,   SAT ? 9 : 0,  SAT ? 1 : 0, SAT ? 0 : 1, 1);
    add(0, 0, 0, 0,  1, 0,   SAT ? 8 : 9,  0,          SAT ? 0 : 1, 1);
    add(0, 0, 0, 0,  0, 0,   SAT ? 8 : 9,  0,          0,          1);
    add(0, 0, 1, 4,  0, 1,   4,            0,          0,          1);

    #1;
    foreach (vecs[i]) begin
      rst_a         = vecs[i].rst[0];
      bus_a.clear   = vecs[i].clear[0];
      bus_a.load    = vecs[i].load[0];
      bus_a.data_in = vecs[i].din[3:0];
      bus_a.enable  = vecs[i].en[0];
      bus_a.up_down = vecs[i].up[0];
      edge_wait();
      chk("data_out", i, int'(bus_a.data_out), vecs[i].q);
      chk("tc", i, int'(bus_a.tc), vecs[i].tc);
      chk("wrap", i, int'(bus_a.wrap), vecs[i].wrap);
      chk("ovf_sticky", i, int'(bus_a.ovf_sticky), vecs[i].ovf);
    end
    rst_a = 1'b0; bus_a.clear = 1'b0; bus_a.load = 1'b0; bus_a.enable = 1'b0;

    // tc must follow up_down without waiting for an edge.
    bus_a.up_down = 1'b0;
    #2;
    chk("tc_comb_down", 0, int'(bus_a.tc), 0);
    bus_a.load = 1'b1; bus_a.data_in = 4'd0;
    edge_wait();
    bus_a.load = 1'b0;
    chk("tc_comb_zero", 0, int'(bus_a.tc), 1);
    bus_a.up_down = 1'b1;
    #2;
    chk("tc_comb_up", 0, int'(bus_a.tc), 0);

    // Prescale-3 copy: enable dropped for two cycles mid-phase, then a load while a tick is due.
    rst_b = 1'b1;
    edge_wait();
    rst_b = 1'b0;
    chk("b_reset", 0, int'(bus_b.data_out), 0);
    en_b  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_b = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 6, 6, 6, 7};
    bus_b.up_down = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus_b.enable  = en_b[k][0];
      bus_b.load    = (k == 13);
      bus_b.data_in = 4'd6;
      edge_wait();
      chk("b_prescale", k, int'(bus_b.data_out), exp_b[k]);
    end
    bus_b.enable = 1'b0;
    bus_b.load   = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

- Parametrised loadable up/down counter: programmable width, modulus, prescaler, terminal-count and wrap flags.
- Next-generation counter DUT for the counter UVM bench; replaces the fixed 4-bit load/count block.
- Uses the same clock/rst/load/data_in/data_out signal set, so the existing driver and monitors extend to it.
- Adds direction, enable, clear and wrap reporting.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- MOD_MAX, 2**WIDTH-1: highest count value, so the count range is 0..MOD_MAX. Must be < 2**WIDTH; violation is an elaboration error.
- PRESCALE, 1: enabled cycles per count step; legal range 1..256. A value of 1 means every enabled cycle counts.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- clear  input  1  synchronous clear to 0; also clears the flags and the prescaler.
- load  input  1  load data_in into the counter.
- data_in  input  WIDTH  load value.
- enable  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- data_out  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational decode of registers and up_down).
- wrap  output  1  one-cycle pulse, registered.
- ovf_sticky  output  1  sticky wrap/saturate flag.

## Operation
- Priority, evaluated at each rising clock edge: rst > clear > load > count step.
- Count step: occurs on a cycle with enable=1 where the prescaler is at PRESCALE-1.
- rst or clear: data_out=0, wrap=0, ovf_sticky=0, prescaler=0.
- load:
  - data_out = data_in if data_in <= MOD_MAX, else MOD_MAX (clamp).
  - Prescaler resets to 0; wrap=0; ovf_sticky unchanged.
- Count up: data_out+1; at MOD_MAX the next value is 0, with wrap=1 for one cycle and ovf_sticky set.
- Count down: data_out-1; at 0 the next value is MOD_MAX, with the same wrap/ovf_sticky behaviour.
- Prescaler:
  - Advances only when enable=1; holds when enable=0.
  - Wraps at PRESCALE-1 and issues an internal tick.
  - With PRESCALE=1 the tick equals enable.
- tc = (up_down && data_out==MOD_MAX) || (!up_down && data_out==0). Combinational, so tc follows an up_down change in the same cycle.
- Arithmetic: performed in WIDTH+1 bits internally; the result is truncated only after the modulus compare. No modulo-2**WIDTH aliasing when MOD_MAX < 2**WIDTH-1.
- up_down may change on any cycle; the step uses its value sampled at that edge.

## Timing
- Latency: load, step, clear and rst each take effect on data_out at the same edge they are sampled, so the new value is visible 1 cycle after the inputs are driven.
- wrap is asserted in the cycle after the edge where the wrap occurred, for exactly one cycle unless a wrap occurs again at the next edge.
- ovf_sticky rises together with wrap.
- Reset mid-count: the edge that samples rst=1 zeroes all state regardless of load, clear or enable. No partial state survives.
- load and a step on the same edge: load wins, and the prescaler phase restarts.
- Bench sampling: inputs are driven and outputs sampled with a 1-time-unit skew around posedge clock. The RTL must not depend on any setup within that skew.

## Configuration
- Macro: MOD_UPDOWN_COUNTER_SAT_EN.
- Defined (saturating mode):
  - Counting up at MOD_MAX holds at MOD_MAX; counting down at 0 holds at 0.
  - wrap is never asserted.
  - ovf_sticky sets on the first step attempted while at the limit.
- Undefined: wrap-around behaviour as described in Operation.
- Port list is identical in both builds.

## Structure
- Shared package counter_pkg holds:
  - Enum dir_e with DIR_DOWN=0 and DIR_UP=1.
  - Localparam function for the prescaler counter width: $clog2(PRESCALE) with a minimum of 1.
  - Result-select constants shared with the scoreboard reference model.
- Sub-module counter_prescaler:
  - Parameter PRESCALE.
  - Inputs: clock, rst, restart, enable. Output: tick.
  - rst, clear and load all drive restart.
- Top level: count register, next-value mux, terminal decode and flags.

## Test plan
- Reset/load: with WIDTH=4, MOD_MAX=9, assert rst, then load data_in=7 -> data_out=0 during reset, then 7.
- Clamp: load data_in=12 -> data_out=9.
- Up wrap: up_down=1, enable=1 from 8 -> sequence 8, 9, 0.
  - tc=1 at 9.
  - wrap pulses one cycle after the 9->0 edge.
  - ovf_sticky=1 and stays high.
- Down wrap: up_down=0 from 1 -> sequence 1, 0, 9; wrap pulses once.
  - With MOD_UPDOWN_COUNTER_SAT_EN defined -> sequence 1, 0, 0; wrap stays 0; ovf_sticky=1.
- Prescaler: PRESCALE=3, enable held high from 0 -> data_out increments every third cycle.
  - Dropping enable for 2 cycles stretches the interval by exactly 2 cycles.
- Priority collisions:
  - load=1 and clear=1 on the same edge -> data_out=0.
  - rst=1 with load=1 and data_in=5 -> data_out=0 and all flags 0.
  - load=1 while a count tick is due -> loaded value, no step.
